// File: rtl/top3_select.sv
// top3_select: streaming top-3 selector for the gesture classifier.
// Takes one signed score per accepted beat (class index order), keeps a sorted
// top-3 of (score, index) pairs and publishes the three indices once per frame.
// Optional feature: define TOP3_SELECT_THRESH_EN to add a confidence floor
// (i_thresh) that suppresses the update and flags o_reject instead.
module top3_select #(
  parameter int N_CLASS = 27,
  parameter int SCORE_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [SCORE_W-1:0] i_score,
`ifdef TOP3_SELECT_THRESH_EN
  input  logic [SCORE_W-1:0] i_thresh,
  output logic               o_reject,
`endif
  output logic               o_ready,
  output logic [4:0]         o_tops      [0:2],
  output logic [4:0]         o_prev_tops [0:2],
  output logic [SCORE_W-1:0] o_top_score,
  output logic               o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0]                LAST_IDX = 5'(N_CLASS - 1);
  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic signed [SCORE_W-1:0] cand_score_q [0:2];
  logic signed [SCORE_W-1:0] cand_score_d [0:2];
  logic [4:0]                cand_idx_q   [0:2];
  logic [4:0]                cand_idx_d   [0:2];
  logic [4:0]                tops_q       [0:2];
  logic [4:0]                tops_d       [0:2];
  logic [4:0]                prev_tops_q  [0:2];
  logic [4:0]                prev_tops_d  [0:2];
  logic [SCORE_W-1:0]        top_score_q, top_score_d;
  logic                      done_q, done_d;
  logic                      reject_q, reject_d;
  logic                      publish;

  logic signed [SCORE_W-1:0] score_s;
  assign score_s = $signed(i_score);

  // Decide whether S_DONE publishes the candidates (threshold gate when enabled).
  always_comb begin
    publish  = 1'b1;
    reject_d = 1'b0;
`ifdef TOP3_SELECT_THRESH_EN
    if (state_q == S_DONE && cand_score_q[0] < $signed(i_thresh)) begin
      publish  = 1'b0;
      reject_d = 1'b1;
    end
`endif
  end

  // Next-state, sorted insertion and output-publish logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_score_d = cand_score_q;
    cand_idx_d   = cand_idx_q;
    tops_d      = tops_q;
    prev_tops_d = prev_tops_q;
    top_score_d = top_score_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          for (int i = 0; i < 3; i++) begin
            cand_score_d[i] = MOST_NEG;
            cand_idx_d[i]   = 5'd0;
          end
          cnt_d   = 5'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (i_valid) begin
          // Strictly-greater compare keeps the earlier index ahead on ties.
          if (score_s > cand_score_q[0]) begin
            cand_score_d[2] = cand_score_q[1];
            cand_idx_d[2]   = cand_idx_q[1];
            cand_score_d[1] = cand_score_q[0];
            cand_idx_d[1]   = cand_idx_q[0];
            cand_score_d[0] = score_s;
            cand_idx_d[0]   = cnt_q;
          end else if (score_s > cand_score_q[1]) begin
            cand_score_d[2] = cand_score_q[1];
            cand_idx_d[2]   = cand_idx_q[1];
            cand_score_d[1] = score_s;
            cand_idx_d[1]   = cnt_q;
          end else if (score_s > cand_score_q[2]) begin
            cand_score_d[2] = score_s;
            cand_idx_d[2]   = cnt_q;
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (publish) begin
          prev_tops_d = tops_q;
          tops_d      = cand_idx_q;
          top_score_d = cand_score_q[0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any frame in progress immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      top_score_q <= '0;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cand_score_q[i] <= '0;
        cand_idx_q[i]   <= 5'd0;
        tops_q[i]       <= 5'd0;
        prev_tops_q[i]  <= 5'd0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      top_score_q  <= top_score_d;
      done_q       <= done_d;
      reject_q     <= reject_d;
      cand_score_q <= cand_score_d;
      cand_idx_q   <= cand_idx_d;
      tops_q       <= tops_d;
      prev_tops_q  <= prev_tops_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_out
      assign o_tops[gi]      = tops_q[gi];
      assign o_prev_tops[gi] = prev_tops_q[gi];
    end
  endgenerate

  assign o_ready     = (state_q == S_SCAN);
  assign o_top_score = top_score_q;
  assign o_done      = done_q;
`ifdef TOP3_SELECT_THRESH_EN
  assign o_reject    = reject_q;
`else
  logic unused_reject;
  assign unused_reject = reject_q;
`endif

endmodule
